// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Double-buffered BCD value committed only on the frame wrap edge; leading-zero blanking optional.
module sevenseg_scan #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [4*NDIGITS-1:0]       value,
  input  logic                       blank_lz,
  output logic [3:0]                 data,
  output logic [NDIGITS-1:0]         anode,
  output logic [$clog2(NDIGITS)-1:0] digit_idx,
  output logic                       frame_done,
  output logic                       pending
);
  localparam int IDXW = $clog2(NDIGITS);
  localparam int DIVW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIVW-1:0]      div_q, div_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [4*NDIGITS-1:0] disp_q, disp_d;
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 frame_done_q, frame_done_d;

  logic slot_end, wrap;

  assign slot_end = (div_q == DIVW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx_q == IDXW'(NDIGITS - 1));

  always_comb begin
    div_d        = slot_end ? '0 : div_q + DIVW'(1);
    idx_d        = idx_q;
    disp_d       = disp_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = wrap;
    if (slot_end) idx_d = wrap ? '0 : idx_q + IDXW'(1);
    if (load) shadow_d = value;
    // A load landing on the wrap edge goes straight to the display and never pends.
    if (wrap) begin
      if (load)           disp_d = value;
      else if (pending_q) disp_d = shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // upper_zero[k]: digit k and every digit above it are zero.
  logic [NDIGITS-1:0] upper_zero;
  logic               blank;

  always_comb begin
    upper_zero[NDIGITS-1] = (disp_q[4*(NDIGITS-1) +: 4] == 4'h0);
    for (int k = NDIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (disp_q[4*k +: 4] == 4'h0);
    end
  end

  assign blank = blank_lz && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    anode = '1;
    if (!blank) anode[idx_q] = 1'b0;
  end

  assign data       = disp_q[{idx_q, 2'b00} +: 4];
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed scenarios then random loads/resets, checked against a
// cycle-count based model of the scan position and frame-boundary commit.
module tb_sevenseg_scan;
  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * R;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    data, data1;
  logic [N-1:0]  anode, anode1;
  logic [1:0]    digit_idx, digit_idx1;
  logic          frame_done, frame_done1, pending, pending1;

  sevenseg_scan #(.NDIGITS(N), .REFRESH_DIV(R)) u_dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
    .data(data), .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done),
    .pending(pending)
  );

  sevenseg_scan #(.NDIGITS(N), .REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
    .data(data1), .anode(anode1), .digit_idx(digit_idx1), .frame_done(frame_done1),
    .pending(pending1)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          t = 0;           // cycles since reset release
  logic [15:0] m_disp = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic cycle(input logic ld, input logic [15:0] val, input logic blk, input logic rst);
    int         idx;
    logic [3:0] exp_anode;
    logic       wrap;
    load = ld; value = val; blank_lz = blk; reset = rst;
    #1;
    idx = (t / R) % N;
    exp_anode = 4'hF;
    if (!(blk && idx > 0 && (m_disp >> (4 * idx)) == 16'h0)) exp_anode[idx] = 1'b0;
    chk("data", 32'(data), 32'(m_disp[4*idx +: 4]));
    chk("anode", 32'(anode), 32'(exp_anode));
    chk("digit_idx", 32'(digit_idx), 32'(idx));
    chk("frame_done", 32'(frame_done), 32'(t > 0 && t % F == 0));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("div1_idx", 32'(digit_idx1), 32'(t % N));
    chk("div1_frame_done", 32'(frame_done1), 32'(t > 0 && t % N == 0));
    @(posedge clk);
    if (rst) begin
      t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    end else begin
      wrap = (t % F) == F - 1;
      if (wrap) begin
        if (ld) m_disp = val;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      if (ld) m_shadow = val;
      t++;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic blk);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, blk, 1'b0);
  endtask

  task automatic align(input int k, input logic blk);
    while (t % F != k) cycle(1'b0, 16'h0, blk, 1'b0);
  endtask

  initial begin
    logic        rblk;
    logic [15:0] rval;
    repeat (3) @(posedge clk);
    #1;
    // Reset release, scan of zeros, load of 1234 at cycle 2.
    idle(2, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    idle(2 * F, 1'b0);
    // Load exactly on the wrap edge.
    align(F - 1, 1'b0);
    cycle(1'b1, 16'h0987, 1'b0, 1'b0);
    idle(F, 1'b0);
    // Last load wins.
    align(3, 1'b0);
    cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    idle(4, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    idle(2 * F, 1'b0);
    // Leading-zero blanking.
    cycle(1'b1, 16'h0045, 1'b1, 1'b0);
    idle(2 * F, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0);
    idle(2 * F, 1'b1);
    cycle(1'b1, 16'h0500, 1'b1, 1'b0);
    idle(2 * F, 1'b1);
    idle(F, 1'b0);
    // Reset mid-frame discards a pending value; load coincident with reset is dropped.
    align(5, 1'b0);
    cycle(1'b1, 16'hF000, 1'b0, 1'b0);
    align(10, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    idle(F + 2, 1'b0);
    cycle(1'b1, 16'hABCD, 1'b0, 1'b1);
    idle(F + 2, 1'b0);
    // Reload invalid nibble; held load counts each cycle.
    cycle(1'b1, 16'hF000, 1'b0, 1'b0);
    idle(2 * F, 1'b0);
    cycle(1'b1, 16'h1000, 1'b0, 1'b0);
    cycle(1'b1, 16'h2000, 1'b0, 1'b0);
    cycle(1'b1, 16'h3E00, 1'b0, 1'b0);
    idle(2 * F, 1'b0);
    // Random traffic.
    rblk = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) rblk = 1'($urandom_range(0, 1));
      rval = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      cycle(1'($urandom_range(0, 7) == 0), rval, rblk, 1'($urandom_range(0, 299) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a packed multi-digit BCD value and steps through the digits at a programmable refresh rate. For each digit slot it presents one 4-bit nibble on `data`, which feeds the existing `sevenseg` decoder directly, and drives the matching active-low digit-enable. New values are double-buffered and committed only at a frame boundary, so a digit never shows a mix of old and new values.

## Interface
- `NDIGITS`, 4: number of digits scanned; must be ≥ 2.
- `REFRESH_DIV`, 1000: clock cycles each digit stays enabled; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `value` into the shadow register.
- `value`  in  4*NDIGITS  packed digits; bits [3:0] are digit 0 (rightmost, least significant).
- `blank_lz`  in  1  when high, leading-zero digits are blanked.
- `data`  out  4  nibble for the current digit; connects to `sevenseg.data`.
- `anode`  out  NDIGITS  active-low digit enables; at most one bit is low.
- `digit_idx`  out  $clog2(NDIGITS)  index of the current digit.
- `frame_done`  out  1  one-cycle pulse on the cycle the index wraps to 0.
- `pending`  out  1  the shadow register holds a value not yet committed.

## Operation
- **State:**
  - `div_cnt` counts 0..REFRESH_DIV-1.
  - `digit_idx` counts 0..NDIGITS-1.
  - `disp_reg` is the displayed value; `shadow_reg` is the loaded value.
  - `pending` flag.
- **Divider:** `div_cnt` increments every cycle. At REFRESH_DIV-1 it returns to 0 and `digit_idx` advances. From NDIGITS-1, `digit_idx` wraps to 0; this is the *wrap edge*.
- **Outputs:** `data` = `disp_reg[4*digit_idx +: 4]`, decoded combinationally from registers.
  - `anode` is all ones except bit `digit_idx`, which is low.
  - The exception is a blanked digit, which has all `anode` bits high.
- **Leading-zero blanking:** when `blank_lz`=1, a digit k > 0 is blanked if it and every digit above it are 0. Digit 0 is never blanked. `data` still carries the nibble during a blanked slot.
- **Out-of-range nibbles (0xA–0xF):** passed to `data` unmodified. Decoding them is the job of `sevenseg`.
- **Load handshake:**
  - `load`=1 writes `shadow_reg` <= `value` and sets `pending`.
  - A second load before commit overwrites `shadow_reg`; the last load wins.
- **Commit:** on the wrap edge, if `pending`=1, then `disp_reg` <= `shadow_reg` and `pending` <= 0.
- **Load on the wrap edge:** `value` bypasses the shadow register straight into `disp_reg`, `shadow_reg` is also updated, and `pending` stays 0.
- **`frame_done`:** registered high for exactly the cycle in which `digit_idx` = 0 following a wrap edge.

## Timing
- **Reset values:** `div_cnt`=0, `digit_idx`=0, `disp_reg`=0, `shadow_reg`=0, `pending`=0, `frame_done`=0.
  - Hence `data`=4'h0 and `anode`=1110 (for NDIGITS=4) in the first cycle after reset.
- **Reset mid-operation:** returns to the reset state on the next edge. It discards any pending value and any `load` asserted in the same cycle.
- **Slot and frame length:** each digit is enabled for exactly REFRESH_DIV cycles. One frame is NDIGITS*REFRESH_DIV cycles.
- **`frame_done` period:** first pulse at cycle NDIGITS*REFRESH_DIV after reset release, then every NDIGITS*REFRESH_DIV cycles.
- **REFRESH_DIV=1:** the digit advances every cycle and every fourth cycle is a wrap edge.
- **Load latency:** `pending` rises the cycle after `load`. The new value appears on `data` in the first cycle of the next frame (digit 0), i.e. at most NDIGITS*REFRESH_DIV cycles after `load`.
- **`load` held high for several cycles:** each cycle is treated as a separate load.

## Test plan
- **Reset and scan:** REFRESH_DIV=4, NDIGITS=4, release reset.
  - `anode` is 1110 for 4 cycles, then 1101, 1011, 0111 (4 cycles each), then back to 1110.
  - `frame_done`=1 on cycle 16 only; `data`=0 throughout.
- **Frame-synchronous load:** `load` with `value`=16'h1234 at cycle 2.
  - `pending`=1 from cycle 3 and `data` stays 0 until cycle 16.
  - Then `data` = 4, 3, 2, 1 for 4 cycles each; `pending`=0 from cycle 16.
- **Load on the wrap edge:** `load` 16'h0987 in the same cycle as the wrap edge.
  - Digit 0 shows 7 immediately and `pending` never rises.
- **Last load wins:** loads of 16'h1111 then 16'h2222 within one frame; the next frame shows only 2s.
- **Leading-zero blanking:** `blank_lz`=1 with 16'h0045.
  - Digit slots 2 and 3 have `anode`=1111; digits 0 and 1 show 5 and 4.
  - With 16'h0000, only digit 0 is enabled. With `blank_lz`=0, all four digits are enabled.
- **Reset mid-frame and invalid nibble:**
  - Load 16'hF000 and assert `reset` at cycle 10 before commit: `pending`=0 and `data`=0 after reset.
  - Reload 16'hF000 without reset: digit 3 presents `data`=4'hF.
